registro_etapa_skid: RTL and testbench

Parameterized two-entry skid-buffer pipeline register placed directly downstream of the 2:1 operand/result multiplexer. It captures the multiplexer's `salida` word and hands it to the next pipeline stage over a valid/ready handshake. The upstream ready is driven from a register, never combinationally from downstream ready, which breaks the timing path. A synchronous flush discards in-flight data on branch/exception.

---
 rtl/registro_etapa_skid_if.sv | 27 ++
 rtl/registro_etapa_skid.sv | 96 +++++++++
 tb/tb_registro_etapa_skid.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/registro_etapa_skid_if.sv
// Valid/ready handshake bundle between the operand/result multiplexer,
// the skid register and the next pipeline stage.
`timescale 1ns/1ps
interface registro_etapa_skid_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dato_entrada;
  logic             valido_entrada;
  logic             listo_entrada;
  logic [WIDTH-1:0] dato_salida;
  logic             valido_salida;
  logic             listo_salida;
  logic             vaciar;
  logic [1:0]       ocupacion;

  // Pipeline-register side.
  modport slave (
    input  dato_entrada, valido_entrada, listo_salida, vaciar,
    output listo_entrada, dato_salida, valido_salida, ocupacion
  );

  // Side that drives upstream data and consumes the output.
  modport master (
    output dato_entrada, valido_entrada, listo_salida, vaciar,
    input  listo_entrada, dato_salida, valido_salida, ocupacion
  );
endinterface

// File: rtl/registro_etapa_skid.sv
// Two-entry skid-buffer pipeline register behind the 2:1 operand/result mux.
// All handshake outputs decode from registered state only.
`timescale 1ns/1ps
module registro_etapa_skid #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  registro_etapa_skid_if.slave  bus
);

  // state  | meaning
  // VACIO  | no word held, ready for input
  // UNO    | one word in principal, ready for input
  // LLENO  | principal and skid both held, upstream stalled
  typedef enum logic [1:0] {
    VACIO = 2'd0,
    UNO   = 2'd1,
    LLENO = 2'd2
  } estado_e;

  estado_e          estado_q, estado_d;
  logic [WIDTH-1:0] principal_q, principal_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             entra;
  logic             sale;

  assign entra = bus.valido_entrada && (estado_q != LLENO);
  assign sale  = bus.listo_salida && (estado_q != VACIO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= VACIO;
      principal_q <= '0;
      skid_q      <= '0;
    end else begin
      estado_q    <= estado_d;
      principal_q <= principal_d;
      skid_q      <= skid_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    principal_d = principal_q;
    skid_d      = skid_q;
    if (bus.vaciar) begin
      // Flush wins over any transfer in the same cycle.
      estado_d    = VACIO;
      principal_d = '0;
      skid_d      = '0;
    end else begin
      case (estado_q)
        VACIO: begin
          if (entra) begin
            estado_d    = UNO;
            principal_d = bus.dato_entrada;
          end
        end
        UNO: begin
          if (entra && sale) begin
            principal_d = bus.dato_entrada;
          end else if (entra) begin
            estado_d = LLENO;
            skid_d   = bus.dato_entrada;
          end else if (sale) begin
            estado_d = VACIO;
          end
        end
        LLENO: begin
          if (sale) begin
            estado_d    = UNO;
            principal_d = skid_q;
          end
        end
        default: begin
          estado_d = VACIO;
        end
      endcase
    end
  end

  always_comb begin
    bus.ocupacion = 2'd0;
    case (estado_q)
      UNO:     bus.ocupacion = 2'd1;
      LLENO:   bus.ocupacion = 2'd2;
      default: bus.ocupacion = 2'd0;
    endcase
  end

  assign bus.valido_salida = (estado_q != VACIO);
  assign bus.listo_entrada = (estado_q != LLENO);
  assign bus.dato_salida   = principal_q;

endmodule

// File: tb/tb_registro_etapa_skid.sv
// Bench for registro_etapa_skid: directed scenarios plus randomized traffic
// compared against a FIFO-of-words reference model.
`timescale 1ns/1ps
module tb_registro_etapa_skid;
  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [WIDTH-1:0] modelo[$];

  registro_etapa_skid_if #(.WIDTH(WIDTH)) bus ();

  registro_etapa_skid #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: up to two words in arrival order; input accepted when fewer than two held.
  task automatic tick();
    bit acepta;
    bit entrega;
    acepta  = bus.valido_entrada && (modelo.size() < 2);
    entrega = bus.listo_salida && (modelo.size() > 0);
    @(posedge clk);
    if (bus.vaciar) begin
      modelo.delete();
    end else begin
      if (entrega) void'(modelo.pop_front());
      if (acepta) modelo.push_back(bus.dato_entrada);
    end
    #1;
  endtask

  task automatic test_reset();
    bus.dato_entrada   = '0;
    bus.valido_entrada = 1'b0;
    bus.listo_salida   = 1'b0;
    bus.vaciar         = 1'b0;
    rst = 1'b1;
    #12;
    checks++;
    if (bus.dato_salida !== 32'h0) begin
      errors++; $display("FAIL reset_dato got=%h exp=%h", bus.dato_salida, 32'h0);
    end
    checks++;
    if (bus.valido_salida !== 1'b0 || bus.ocupacion !== 2'd0 || bus.listo_entrada !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl got v=%b o=%0d l=%b exp v=0 o=0 l=1",
               bus.valido_salida, bus.ocupacion, bus.listo_entrada);
    end
    rst = 1'b0;
    modelo.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_pass_through();
    bus.listo_salida   = 1'b1;
    bus.valido_entrada = 1'b1;
    bus.dato_entrada   = 32'hAAAAAAAA;
    tick();
    checks++;
    if (bus.dato_salida !== 32'hAAAAAAAA || bus.valido_salida !== 1'b1 || bus.ocupacion !== 2'd1) begin
      errors++;
      $display("FAIL pass_first got d=%h v=%b o=%0d exp d=aaaaaaaa v=1 o=1",
               bus.dato_salida, bus.valido_salida, bus.ocupacion);
    end
    bus.dato_entrada = 32'h55555555;
    tick();
    checks++;
    if (bus.dato_salida !== 32'h55555555 || bus.valido_salida !== 1'b1 || bus.ocupacion !== 2'd1) begin
      errors++;
      $display("FAIL pass_second got d=%h v=%b o=%0d exp d=55555555 v=1 o=1",
               bus.dato_salida, bus.valido_salida, bus.ocupacion);
    end
    bus.valido_entrada = 1'b0;
    tick();
    checks++;
    if (bus.valido_salida !== 1'b0 || bus.ocupacion !== 2'd0) begin
      errors++;
      $display("FAIL pass_empty got v=%b o=%0d exp v=0 o=0", bus.valido_salida, bus.ocupacion);
    end
  endtask

  task automatic test_backpressure_fill();
    bus.listo_salida   = 1'b0;
    bus.valido_entrada = 1'b1;
    bus.dato_entrada   = 32'hF0F0F0F0;
    tick();
    checks++;
    if (bus.ocupacion !== 2'd1 || bus.listo_entrada !== 1'b1 || bus.dato_salida !== 32'hF0F0F0F0) begin
      errors++;
      $display("FAIL fill_one got o=%0d l=%b d=%h exp o=1 l=1 d=f0f0f0f0",
               bus.ocupacion, bus.listo_entrada, bus.dato_salida);
    end
    bus.dato_entrada = 32'h0F0F0F0F;
    tick();
    checks++;
    if (bus.ocupacion !== 2'd2 || bus.listo_entrada !== 1'b0 || bus.dato_salida !== 32'hF0F0F0F0) begin
      errors++;
      $display("FAIL fill_two got o=%0d l=%b d=%h exp o=2 l=0 d=f0f0f0f0",
               bus.ocupacion, bus.listo_entrada, bus.dato_salida);
    end
    bus.dato_entrada = 32'hFFFFFFFF;
    tick();
    checks++;
    if (bus.ocupacion !== 2'd2 || bus.dato_salida !== 32'hF0F0F0F0) begin
      errors++;
      $display("FAIL fill_reject got o=%0d d=%h exp o=2 d=f0f0f0f0", bus.ocupacion, bus.dato_salida);
    end
  endtask

  task automatic test_drain();
    bus.listo_salida = 1'b1;
    tick();
    checks++;
    if (bus.dato_salida !== 32'h0F0F0F0F || bus.listo_entrada !== 1'b1 || bus.ocupacion !== 2'd1) begin
      errors++;
      $display("FAIL drain_first got d=%h l=%b o=%0d exp d=0f0f0f0f l=1 o=1",
               bus.dato_salida, bus.listo_entrada, bus.ocupacion);
    end
    tick();
    checks++;
    if (bus.dato_salida !== 32'hFFFFFFFF || bus.valido_salida !== 1'b1) begin
      errors++;
      $display("FAIL drain_second got d=%h v=%b exp d=ffffffff v=1", bus.dato_salida, bus.valido_salida);
    end
    bus.valido_entrada = 1'b0;
    tick();
    checks++;
    if (bus.valido_salida !== 1'b0 || bus.ocupacion !== 2'd0) begin
      errors++;
      $display("FAIL drain_empty got v=%b o=%0d exp v=0 o=0", bus.valido_salida, bus.ocupacion);
    end
  endtask

  task automatic test_simultaneous();
    bus.listo_salida   = 1'b1;
    bus.valido_entrada = 1'b1;
    bus.dato_entrada   = 32'h12345678;
    tick();
    bus.dato_entrada = 32'h9ABCDEF0;
    tick();
    checks++;
    if (bus.ocupacion !== 2'd1 || bus.dato_salida !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL simul got o=%0d d=%h exp o=1 d=9abcdef0", bus.ocupacion, bus.dato_salida);
    end
    bus.valido_entrada = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    bus.listo_salida   = 1'b0;
    bus.valido_entrada = 1'b1;
    bus.dato_entrada   = 32'hA1A1A1A1;
    tick();
    bus.dato_entrada = 32'hB2B2B2B2;
    tick();
    bus.vaciar       = 1'b1;
    bus.dato_entrada = 32'hC3C3C3C3;
    tick();
    checks++;
    if (bus.valido_salida !== 1'b0 || bus.ocupacion !== 2'd0 || bus.dato_salida !== 32'h0 ||
        bus.listo_entrada !== 1'b1) begin
      errors++;
      $display("FAIL flush got v=%b o=%0d d=%h l=%b exp v=0 o=0 d=0 l=1",
               bus.valido_salida, bus.ocupacion, bus.dato_salida, bus.listo_entrada);
    end
    bus.vaciar         = 1'b0;
    bus.valido_entrada = 1'b0;
    bus.listo_salida   = 1'b1;
    tick();
    checks++;
    if (bus.valido_salida !== 1'b0 || bus.dato_salida === 32'hC3C3C3C3) begin
      errors++;
      $display("FAIL flush_drop got v=%b d=%h exp v=0", bus.valido_salida, bus.dato_salida);
    end
  endtask

  task automatic test_async_reset();
    bus.listo_salida   = 1'b0;
    bus.valido_entrada = 1'b1;
    bus.dato_entrada   = 32'hDEADBEEF;
    tick();
    bus.dato_entrada = 32'hCAFEF00D;
    tick();
    bus.valido_entrada = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.valido_salida !== 1'b0 || bus.ocupacion !== 2'd0 || bus.dato_salida !== 32'h0 ||
        bus.listo_entrada !== 1'b1) begin
      errors++;
      $display("FAIL async_rst got v=%b o=%0d d=%h l=%b exp v=0 o=0 d=0 l=1",
               bus.valido_salida, bus.ocupacion, bus.dato_salida, bus.listo_entrada);
    end
    #1;
    rst = 1'b0;
    modelo.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int n_cmp;
    n_cmp = 0;
    for (int i = 0; i < 400; i++) begin
      bus.valido_entrada = ($urandom_range(0, 3) != 0);
      bus.listo_salida   = ($urandom_range(0, 2) != 0);
      bus.vaciar         = ($urandom_range(0, 31) == 0);
      bus.dato_entrada   = $urandom;
      #1;
      // Handshake outputs must not react to inputs before the edge.
      checks++;
      if (bus.listo_entrada !== (modelo.size() < 2) || bus.valido_salida !== (modelo.size() > 0)) begin
        errors++;
        $display("FAIL rnd_pre cyc=%0d got l=%b v=%b exp l=%b v=%b", i,
                 bus.listo_entrada, bus.valido_salida, modelo.size() < 2, modelo.size() > 0);
      end
      tick();
      checks++;
      if (bus.ocupacion !== 2'(modelo.size())) begin
        errors++;
        $display("FAIL rnd_ocup cyc=%0d got %0d exp %0d", i, bus.ocupacion, modelo.size());
      end
      if (modelo.size() > 0) begin
        checks++;
        n_cmp++;
        if (bus.dato_salida !== modelo[0]) begin
          errors++;
          $display("FAIL rnd_dato cyc=%0d got %h exp %h", i, bus.dato_salida, modelo[0]);
        end
      end
    end
    bus.vaciar = 1'b0;
    checks++;
    if (n_cmp < 50) begin
      errors++;
      $display("FAIL rnd_coverage got %0d data compares exp >= 50", n_cmp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pass_through();
    test_backpressure_fill();
    test_drain();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
